// File: rtl/store_unit.sv
// store_unit: turns one MEM-stage store request into byte-lane-masked
// word writes. A store that crosses a word boundary is issued as two beats.
// Optional build macro: STORE_MISALIGN_TRAP_EN. When it is defined, a
// crossing store raises misalign_fault for one cycle and writes nothing.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// BEAT0 | first (or only) word write, held until mem_ready
// BEAT1 | second word write of a split store, held until mem_ready
module store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        save_method,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  output logic              store_done,
  output logic              misalign_fault
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-3:0]   r_waddr;
  logic [7:0]          r_mask;
  logic [63:0]         r_data;
  logic                r_split;
  logic                r_done;
  logic                r_fault;

  logic [1:0]          w_off;
  logic [3:0]          w_base;
  logic [7:0]          w_mask8;
  logic [63:0]         w_data64;
  logic                w_split;
  logic                w_accept;
  logic                w_done_nxt;
  logic                w_fault_nxt;

  // Decode the incoming request into lane mask and lane-aligned data.
  always_comb begin
    w_off = req_addr[1:0];
    case (save_method)
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      2'b10:   w_base = 4'b1111;
      default: w_base = 4'b0000;
    endcase
    w_mask8  = {4'b0000, w_base} << w_off;
    w_data64 = {32'b0, req_wdata} << {w_off, 3'b000};
    w_split  = |w_mask8[7:4];
  end

  // Next-state, done/fault pulses and memory-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_fault_nxt = 1'b0;
    w_accept    = 1'b0;
    req_ready   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = 4'b0000;
    mem_wdata   = 32'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (save_method == 2'b11) begin
            w_done_nxt = 1'b1;
          end else begin
`ifdef STORE_MISALIGN_TRAP_EN
            if (w_split) begin
              w_fault_nxt = 1'b1;
            end else begin
              w_accept    = 1'b1;
              w_state_nxt = BEAT0;
            end
`else
            w_accept    = 1'b1;
            w_state_nxt = BEAT0;
`endif
          end
        end
      end
      BEAT0: begin
        mem_we    = 1'b1;
        mem_addr  = r_waddr;
        mem_be    = r_mask[3:0];
        mem_wdata = r_data[31:0];
        if (mem_ready) begin
          if (r_split) begin
            w_state_nxt = BEAT1;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      BEAT1: begin
        mem_we    = 1'b1;
        mem_addr  = r_waddr + 1'b1;
        mem_be    = r_mask[7:4];
        mem_wdata = r_data[63:32];
        if (mem_ready) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and request capture; reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_waddr <= '0;
      r_mask  <= 8'h00;
      r_data  <= 64'h0;
      r_split <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_fault <= w_fault_nxt;
      if (w_accept) begin
        r_waddr <= req_addr[ADDR_W-1:2];
        r_mask  <= w_mask8;
        r_data  <= w_data64;
        r_split <= w_split;
      end
    end
  end

  assign store_done = r_done;
`ifdef STORE_MISALIGN_TRAP_EN
  assign misalign_fault = r_fault;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with hand-computed expectations.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  save_method;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        store_done;
  logic        misalign_fault;

  int n_cmp = 0;
  int n_err = 0;

  store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .save_method(save_method),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready),
    .store_done(store_done), .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [29:0] a, input logic [3:0] be,
                      input logic [31:0] d);
    chk({tag, " we"}, 64'(mem_we), 64'd1);
    chk({tag, " addr"}, 64'(mem_addr), 64'(a));
    chk({tag, " be"}, 64'(mem_be), 64'(be));
    chk({tag, " data"}, 64'(mem_wdata), 64'(d));
    chk({tag, " ready"}, 64'(req_ready), 64'd0);
    chk({tag, " done"}, 64'(store_done), 64'd0);
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    req_valid   = 1'b1;
    req_addr    = a;
    req_wdata   = d;
    save_method = m;
    tick();
    req_valid   = 1'b0;
  endtask

  task automatic done_check(input string tag);
    chk({tag, " done"}, 64'(store_done), 64'd1);
    chk({tag, " we idle"}, 64'(mem_we), 64'd0);
    chk({tag, " ready idle"}, 64'(req_ready), 64'd1);
    tick();
    chk({tag, " done drop"}, 64'(store_done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    save_method = 2'b00; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst ready", 64'(req_ready), 64'd1);
    chk("rst we", 64'(mem_we), 64'd0);
    chk("rst addr", 64'(mem_addr), 64'd0);
    chk("rst be", 64'(mem_be), 64'd0);
    chk("rst data", 64'(mem_wdata), 64'd0);
    chk("rst done", 64'(store_done), 64'd0);
    chk("rst fault", 64'(misalign_fault), 64'd0);

    // Byte store
    mem_ready = 1'b1;
    req(32'h1002, 32'h0000_00A5, 2'b00);
    beat("byte", 30'h400, 4'b0100, 32'h00A5_0000);
    tick();
    done_check("byte");

    // Aligned word with three stall cycles
    mem_ready = 1'b0;
    req(32'h20, 32'hDEAD_BEEF, 2'b10);
    for (int i = 0; i < 3; i++) begin
      beat("stall", 30'h8, 4'b1111, 32'hDEAD_BEEF);
      tick();
    end
    mem_ready = 1'b1;
    beat("stall last", 30'h8, 4'b1111, 32'hDEAD_BEEF);
    tick();
    done_check("stall");

`ifdef STORE_MISALIGN_TRAP_EN
    req(32'h2, 32'h1234_5678, 2'b10);
    chk("trap we", 64'(mem_we), 64'd0);
    chk("trap fault", 64'(misalign_fault), 64'd1);
    chk("trap ready", 64'(req_ready), 64'd1);
    chk("trap done", 64'(store_done), 64'd0);
    tick();
    chk("trap fault drop", 64'(misalign_fault), 64'd0);
    chk("trap done after", 64'(store_done), 64'd0);
    chk("trap we after", 64'(mem_we), 64'd0);
`else
    // Split word store
    req(32'h103, 32'h1122_3344, 2'b10);
    chk("split fault", 64'(misalign_fault), 64'd0);
    beat("split b0", 30'h40, 4'b1000, 32'h4400_0000);
    tick();
    beat("split b1", 30'h41, 4'b0111, 32'h0011_2233);
    tick();
    done_check("split");

    // Half store wrapping at top of address space
    req(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
    beat("wrap b0", 30'h3FFF_FFFF, 4'b1000, 32'hEF00_0000);
    tick();
    beat("wrap b1", 30'h0, 4'b0001, 32'h0000_00BE);
    tick();
    done_check("wrap");

    // Reset during BEAT1
    req(32'h103, 32'h1122_3344, 2'b10);
    tick();
    beat("rstmid b1", 30'h41, 4'b0111, 32'h0011_2233);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid we", 64'(mem_we), 64'd0);
    chk("rstmid ready", 64'(req_ready), 64'd1);
    chk("rstmid done", 64'(store_done), 64'd0);
    tick();
    chk("rstmid done later", 64'(store_done), 64'd0);
`endif

    // Reserved code: no write, done next cycle
    req(32'h44, 32'hFFFF_FFFF, 2'b11);
    chk("rsvd we", 64'(mem_we), 64'd0);
    done_check("rsvd");

    // Aligned store after everything above
    req(32'h40, 32'hCAFE_F00D, 2'b10);
    beat("post", 30'h10, 4'b1111, 32'hCAFE_F00D);
    tick();
    done_check("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Downstream consumer of the store-width code produced by the store-width decoder.
- Takes one store request per transaction from the MEM stage and turns it into byte-lane-masked word writes to the word-wide data memory.
- Splits misaligned stores that cross a word boundary into two sequential word writes.
- Holds the pipeline off, via a valid/ready handshake, until the whole store has been accepted by memory.

Parameters:
- ADDR_W, 32, byte-address width; word address is ADDR_W-2 bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- save_method  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-aligned write data
- mem_be  out  4  byte enables; bit i = bits [8i+7:8i]
- mem_ready  in  1  memory accepts the current beat this cycle
- store_done  out  1  one-cycle pulse when the store is fully retired
- misalign_fault  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (synchronous): state=IDLE; req_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; mem_be=0; store_done=0; misalign_fault=0. All captured request registers are cleared.
- Reset mid-operation: an in-flight beat is dropped; a split store may be left half-written; no store_done pulse.
- Request decode, with off = req_addr[1:0]:
  - mask8 = base << off, where base = 0001 (byte), 0011 (half), 1111 (word).
  - data64 = {32'b0, req_wdata} << (8*off).
  - split = |mask8[7:4].
  - All of this is computed at acceptance and registered.
- States: IDLE, BEAT0, BEAT1.
- IDLE:
  - req_ready=1; mem_we=0.
  - On req_valid & req_ready with save_method != 11: go to BEAT0.
  - On save_method = 11: no write; stay IDLE; store_done=1 next cycle.
- BEAT0:
  - req_ready=0; mem_we=1; mem_addr = req_addr[ADDR_W-1:2]; mem_be = mask8[3:0]; mem_wdata = data64[31:0].
  - Outputs are held stable until mem_ready.
  - On mem_ready: if split, go to BEAT1; otherwise go to IDLE with store_done=1 in the following cycle.
- BEAT1:
  - mem_we=1; mem_addr = word address + 1, wrapping modulo 2^(ADDR_W-2) (address 0xFFFFFFFF wraps to word 0); mem_be = mask8[7:4]; mem_wdata = data64[63:32].
  - On mem_ready: go to IDLE; store_done=1 in the following cycle.
- Latency: aligned store needs 1 cycle accept plus at least 1 beat cycle; done is visible on cycle 2 at the earliest. Split store needs at least 3 cycles to done.
- Back-to-back: in the cycle store_done=1 the unit is in IDLE with req_ready=1, so a new request may be accepted that same cycle.
- req_* inputs are ignored while req_ready=0; the upstream stage must hold them.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: a request with split=1 (half at off 3; word at off 1–3) is accepted but issues no memory write. misalign_fault=1 for exactly one cycle (the cycle after acceptance), then the unit returns to IDLE. store_done does not pulse. Aligned stores behave as without the macro.
- Undefined: misaligned stores are split as described above; misalign_fault is constant 0.

Test Plan:
- Byte store: addr=0x1002, wdata=0xA5, method=00, mem_ready=1 → one beat: mem_addr=0x400, be=0100, wdata=0x00A50000; store_done on cycle 2.
- Word store aligned with memory stall: addr=0x20, wdata=0xDEADBEEF, mem_ready low 3 cycles → mem_we/addr/be=1111/data held 3 cycles; req_ready=0 throughout; single done pulse.
- Split word store: addr=0x103, wdata=0x11223344 → beat0: addr 0x40, be=1000, data=0x44000000; beat1: addr 0x41, be=0111, data=0x00112233; done once.
- Wrap and reserved code: half store at addr=0xFFFFFFFF, wdata=0xBEEF → beat1 mem_addr=0, be=0001, data=0xBE. Then method=11 → no mem_we; store_done next cycle.
- Reset during BEAT1 of a split store → next cycle mem_we=0, req_ready=1, no store_done; a following aligned store completes normally.
- With STORE_MISALIGN_TRAP_EN defined: word store at addr=0x2 → no mem_we; misalign_fault=1 for 1 cycle; req_ready back to 1.
